// File: rtl/ma_channel_scheduler.sv
// Round-robin scheduler feeding NCH channels through one shared 4-tap moving-average datapath.
// Optional build macro MA_ROUND_EN selects round-half-up output instead of truncation.
module ma_channel_scheduler #(
  parameter int W   = 8,
  parameter int NCH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           s_valid,
  input  logic [NCH*W-1:0]         s_data,
  output logic [NCH-1:0]           s_ready,
  output logic                     m_valid,
  output logic [W-1:0]             m_data,
  output logic [$clog2(NCH)-1:0]   m_chan,
  input  logic                     m_ready
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_g;
  logic [W-1:0]    r_sample;
  logic [W-1:0]    r_h1 [NCH];
  logic [W-1:0]    r_h2 [NCH];
  logic [W-1:0]    r_h3 [NCH];
  logic            r_m_valid;
  logic [W-1:0]    r_m_data;
  logic [CW-1:0]   r_m_chan;

  logic            w_found;
  logic [CW-1:0]   w_gidx;
  logic            w_hs;
  logic [W+1:0]    w_sum;
  logic [W-1:0]    w_avg;

  // Search starts at r_ptr and wraps; the first asserted valid wins.
  always_comb begin
    int unsigned c;
    w_found = 1'b0;
    w_gidx  = '0;
    c       = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = int'(r_ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!w_found && s_valid[c]) begin
        w_found = 1'b1;
        w_gidx  = CW'(c);
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (r_state == IDLE && !rst && w_found)
      s_ready = {{(NCH-1){1'b0}}, 1'b1} << w_gidx;
  end

  assign w_hs = |(s_valid & s_ready);

  always_comb begin
    w_sum = (W+2)'(r_sample) + (W+2)'(r_h1[r_g]) + (W+2)'(r_h2[r_g]) + (W+2)'(r_h3[r_g]);
`ifdef MA_ROUND_EN
    begin
      logic [W+1:0] w_rnd;
      w_rnd = w_sum + (W+2)'(2);
      w_avg = w_rnd[W+1:2];
    end
`else
    w_avg = w_sum[W+1:2];
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = CALC;
      CALC:    w_next = OUT;
      OUT:     if (m_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_g       <= '0;
      r_sample  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_chan  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_h1[i] <= '0;
        r_h2[i] <= '0;
        r_h3[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_sample <= s_data[int'(w_gidx)*W +: W];
            r_g      <= w_gidx;
            r_ptr    <= (w_gidx == CW'(NCH-1)) ? '0 : w_gidx + CW'(1);
          end
        end
        CALC: begin
          r_m_data   <= w_avg;
          r_m_chan   <= r_g;
          r_m_valid  <= 1'b1;
          r_h3[r_g]  <= r_h2[r_g];
          r_h2[r_g]  <= r_h1[r_g];
          r_h1[r_g]  <= r_sample;
        end
        OUT: begin
          if (m_ready) r_m_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_chan  = r_m_chan;

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Directed plus randomized bench for ma_channel_scheduler against a per-channel history model.
module tb_ma_channel_scheduler;
  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int CW  = $clog2(NCH);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NCH-1:0]     s_valid = '0;
  logic [NCH*W-1:0]   s_data = '0;
  logic [NCH-1:0]     s_ready;
  logic               m_valid;
  logic [W-1:0]       m_data;
  logic [CW-1:0]      m_chan;
  logic               m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  int m_ptr;
  int m_hist [NCH][3];

  ma_channel_scheduler #(.W(W), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_chan(m_chan), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    for (int c = 0; c < NCH; c++)
      for (int j = 0; j < 3; j++) m_hist[c][j] = 0;
  endfunction

  function automatic int rr_pick(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++)
      if (v[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    return -1;
  endfunction

  function automatic int avg_of(input int sum);
`ifdef MA_ROUND_EN
    return (sum + 2) / 4;
`else
    return sum / 4;
`endif
  endfunction

  function automatic logic [NCH*W-1:0] rand_data();
    logic [NCH*W-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*W +: W] = W'($urandom);
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_valid = '1; m_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_in_rst", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_in_rst2", 32'(s_ready), 32'd0);
    rst = 1'b0; s_valid = '0; m_ready = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_chan", 32'(m_chan), 32'd0);
    model_reset();
  endtask

  // rmode: 0 normal, 1 reset during CALC, 2 reset during OUT
  task automatic txn(input logic [NCH-1:0] v, input logic [NCH*W-1:0] d, input int hold, input int rmode);
    int g, sample, sum, exp_d;
    logic [NCH*W-1:0] dd;
    s_valid = v; s_data = d; m_ready = 1'($urandom_range(0, 1));
    #1;
    g = rr_pick(v);
    if (g < 0) begin
      chk("ready_none", 32'(s_ready), 32'd0);
      @(posedge clk); #1;
      chk("idle_no_valid", 32'(m_valid), 32'd0);
      return;
    end
    chk("grant", 32'(s_ready), 32'(1) << g);
    @(posedge clk); #1;
    dd = d;
    sample = int'(dd[g*W +: W]);
    m_ptr = (g + 1) % NCH;
    chk("calc_ready", 32'(s_ready), 32'd0);
    chk("calc_valid", 32'(m_valid), 32'd0);
    s_valid = NCH'($urandom); s_data = rand_data(); m_ready = (hold == 0);
    if (rmode == 1) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_calc_valid", 32'(m_valid), 32'd0);
      rst = 1'b0; s_valid = '0; m_ready = 1'b0;
      model_reset();
      return;
    end
    @(posedge clk); #1;
    sum = sample + m_hist[g][0] + m_hist[g][1] + m_hist[g][2];
    exp_d = avg_of(sum);
    m_hist[g][2] = m_hist[g][1]; m_hist[g][1] = m_hist[g][0]; m_hist[g][0] = sample;
    chk("out_valid", 32'(m_valid), 32'd1);
    chk("out_data", 32'(m_data), 32'(exp_d));
    chk("out_chan", 32'(m_chan), 32'(g));
    chk("out_ready", 32'(s_ready), 32'd0);
    if (rmode == 2) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(m_valid), 32'd0);
      chk("rst_out_data", 32'(m_data), 32'd0);
      rst = 1'b0; s_valid = '0; m_ready = 1'b0;
      model_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      s_valid = NCH'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(exp_d));
      chk("hold_chan", 32'(m_chan), 32'(g));
      chk("hold_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", 32'(m_valid), 32'd0);
    g = rr_pick(s_valid);
    chk("idle_grant", 32'(s_ready), (g < 0) ? 32'd0 : (32'(1) << g));
    m_ready = 1'b0; s_valid = '0;
  endtask

  function automatic logic [NCH*W-1:0] one(input int c, input int val);
    logic [NCH*W-1:0] d;
    d = '0;
    d[c*W +: W] = W'(val);
    return d;
  endfunction

  initial begin
    logic [NCH*W-1:0] d;
    model_reset();
    do_reset();

    // channel 0 ramp
    for (int i = 1; i <= 4; i++) txn(NCH'(1), one(0, 4 * i), 0, 0);

    // single sample on channel 1 after reset
    do_reset();
    txn(NCH'(2), one(1, 2), 0, 0);

    // full-scale on ch0 interleaved with zeros on ch1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = one(0, 255) | one(1, 0);
      txn(NCH'(3), d, 0, 0);
    end

    // all channels requesting, downstream always ready
    do_reset();
    for (int i = 0; i < 6; i++) txn('1, rand_data(), 0, 0);

    // downstream stall
    txn(NCH'(8), rand_data(), 5, 0);

    // reset while holding an output on channel 2
    do_reset();
    for (int i = 0; i < 3; i++) txn(NCH'(4), one(2, 40), 0, 0);
    txn(NCH'(4), one(2, 40), 0, 2);
    txn(NCH'(4), one(2, 40), 0, 0);

    // reset during CALC, and an idle cycle with no requests
    txn(NCH'(5), rand_data(), 0, 1);
    txn('0, rand_data(), 0, 0);

    for (int i = 0; i < 80; i++)
      txn(NCH'($urandom), rand_data(), int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
